// File: rtl/alu_issuer_pkg.sv
// Shared types and constants for the ALU op issuer, the ALU wrapper and the bench.
// Optional carry chaining is controlled by ALU_ISSUER_CARRY_CHAIN_EN.
package alu_issuer_pkg;

  localparam int DEF_BITS_SZ  = 32;
  localparam int DEF_CNTRL_SZ = 4;
  localparam int DEF_LAT      = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_NOR = 4'hC;

  // Result plus flags in wrapper order: out, Z, V, N, C.
  typedef struct packed {
    logic [DEF_BITS_SZ-1:0] out;
    logic                   z;
    logic                   v;
    logic                   n;
    logic                   c;
  } alu_rsp_t;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command, ALU-drive and response bundle for the ALU op issuer.
// The slave modport is the issuer; the master modport is its environment.
interface alu_op_issuer_if #(
  parameter int BITS_SZ  = 32,
  parameter int CNTRL_SZ = 4
);
  logic                cmd_valid, cmd_ready;
  logic [BITS_SZ-1:0]  cmd_a, cmd_b;
  logic [CNTRL_SZ-1:0] cmd_op;
  logic                cmd_cin, cmd_chain;

  logic [BITS_SZ-1:0]  alu_a, alu_b;
  logic [CNTRL_SZ-1:0] alu_op;
  logic                alu_cin;
  logic [BITS_SZ-1:0]  alu_out;
  logic                alu_z, alu_v, alu_n, alu_c;

  logic                rsp_valid, rsp_ready;
  logic [BITS_SZ-1:0]  rsp_out;
  logic                rsp_z, rsp_v, rsp_n, rsp_c;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cin, cmd_chain,
    input  alu_out, alu_z, alu_v, alu_n, alu_c, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, alu_cin,
    output rsp_valid, rsp_out, rsp_z, rsp_v, rsp_n, rsp_c
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cin, cmd_chain,
    output alu_out, alu_z, alu_v, alu_n, alu_c, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_cin,
    input  rsp_valid, rsp_out, rsp_z, rsp_v, rsp_n, rsp_c
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Single-op-in-flight driver for the registered ALU wrapper: accept, wait LAT edges, capture, respond.
// ALU_ISSUER_CARRY_CHAIN_EN: cmd_chain selects the previous op's carry as carry-in.
module alu_op_issuer
  import alu_issuer_pkg::*;
#(
  parameter int BITS_SZ  = DEF_BITS_SZ,
  parameter int CNTRL_SZ = DEF_CNTRL_SZ,
  parameter int LAT      = DEF_LAT
) (
  input  logic            clk,
  input  logic            reset,
  alu_op_issuer_if.slave  bus,
  output logic            busy
);

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [BITS_SZ-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CNTRL_SZ-1:0] alu_op_q, alu_op_d;
  logic                alu_cin_q, alu_cin_d;
  logic [BITS_SZ-1:0]  rsp_out_q, rsp_out_d;
  logic [3:0]          rsp_flg_q, rsp_flg_d;   // {z, v, n, c}
  logic                cin_sel;

`ifdef ALU_ISSUER_CARRY_CHAIN_EN
  logic last_c_q, last_c_d;
  assign cin_sel = bus.cmd_chain ? last_c_q : bus.cmd_cin;
`else
  assign cin_sel = bus.cmd_cin;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    rsp_out_d = rsp_out_q;
    rsp_flg_d = rsp_flg_q;
`ifdef ALU_ISSUER_CARRY_CHAIN_EN
    last_c_d  = last_c_q;
`endif
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        alu_a_d   = bus.cmd_a;
        alu_b_d   = bus.cmd_b;
        alu_op_d  = bus.cmd_op;
        alu_cin_d = cin_sel;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      // cnt tracks edges since accept; the wrapper output is valid once it reaches LAT.
      WAIT: if (cnt_q == LAT_C) begin
        rsp_out_d = bus.alu_out;
        rsp_flg_d = {bus.alu_z, bus.alu_v, bus.alu_n, bus.alu_c};
`ifdef ALU_ISSUER_CARRY_CHAIN_EN
        last_c_d  = bus.alu_c;
`endif
        state_d   = RESP;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_cin_q <= 1'b0;
      rsp_out_q <= '0;
      rsp_flg_q <= '0;
`ifdef ALU_ISSUER_CARRY_CHAIN_EN
      last_c_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      rsp_out_q <= rsp_out_d;
      rsp_flg_q <= rsp_flg_d;
`ifdef ALU_ISSUER_CARRY_CHAIN_EN
      last_c_q  <= last_c_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_cin   = alu_cin_q;
  assign bus.rsp_out   = rsp_out_q;
  assign {bus.rsp_z, bus.rsp_v, bus.rsp_n, bus.rsp_c} = rsp_flg_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench: issuer driving a behavioural 2-stage registered ALU wrapper; scoreboard checks responses.
module tb_alu_op_issuer;
  import alu_issuer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  alu_rsp_t sb[$];

  alu_op_issuer_if #(.BITS_SZ(32), .CNTRL_SZ(4)) bus ();

  alu_op_issuer #(.BITS_SZ(32), .CNTRL_SZ(4), .LAT(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU wrapper: input regs, then output regs.
  logic [31:0] ra, rb;
  logic [3:0]  rop;
  logic        rcin;

  function automatic logic [35:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic cin);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      ALU_AND: s = {1'b0, a & b};
      ALU_OR:  s = {1'b0, a | b};
      ALU_NOR: s = {1'b0, ~(a | b)};
      default: s = '0;
    endcase
    r = s[31:0];
    c = s[32];
    return {r, (r == 32'd0), v, r[31], c};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra <= '0; rb <= '0; rop <= '0; rcin <= 1'b0;
      {bus.alu_out, bus.alu_z, bus.alu_v, bus.alu_n, bus.alu_c} <= '0;
    end else begin
      ra <= bus.alu_a; rb <= bus.alu_b; rop <= bus.alu_op; rcin <= bus.alu_cin;
      {bus.alu_out, bus.alu_z, bus.alu_v, bus.alu_n, bus.alu_c} <= alu_f(ra, rb, rop, rcin);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response handshake pops and compares one expected entry.
  always @(negedge clk) begin
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp: got out=%0h expected no response", bus.rsp_out);
      end else begin
        alu_rsp_t e;
        e = sb.pop_front();
        chk("rsp_data", {28'd0, bus.rsp_out, bus.rsp_z, bus.rsp_v, bus.rsp_n, bus.rsp_c}, {28'd0, e});
      end
    end
  end

  int t0;

  // Present a command until accepted; returns with cmd_valid dropped, t0 = cycle of acceptance edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic cin, input logic chain);
    int n;
    @(posedge clk); #1;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_cin = cin; bus.cmd_chain = chain;
    bus.cmd_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    if (n == 50) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    t0 = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (n == 20) chk({name, "_timeout"}, 64'd0, 64'd1);
    else chk({name, "_latency"}, 64'(cyc - t0), 64'd3);
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic cin, input logic chain,
                     input logic exp_cin, input alu_rsp_t exp);
    sb.push_back(exp);
    issue(a, b, op, cin, chain);
    @(negedge clk);
    chk({name, "_alu_cin"}, {63'd0, bus.alu_cin}, {63'd0, exp_cin});
    wait_rsp(name);
    @(negedge clk);
    chk({name, "_rsp_1cycle"}, {63'd0, bus.rsp_valid}, 64'd0);
  endtask

  logic [31:0] snap;
  alu_rsp_t chain_exp;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.cmd_cin = 1'b0; bus.cmd_chain = 1'b0; bus.rsp_ready = 1'b1;

    // 1: reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_alu_a", {32'd0, bus.alu_a}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp_out", {32'd0, bus.rsp_out}, 64'd0);

    // 2: simple add
    run("add5_3", 32'h5, 32'h3, ALU_ADD, 1'b0, 1'b0, 1'b0, '{32'h8, 1'b0, 1'b0, 1'b0, 1'b0});
    // signed overflow / negative flags
    run("add_ovf", 32'h7FFF_FFFF, 32'h1, ALU_ADD, 1'b0, 1'b0, 1'b0,
        '{32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0});
    run("or", 32'hF000_000F, 32'h0F00_00F0, ALU_OR, 1'b1, 1'b0, 1'b1,
        '{32'hFF00_00FF, 1'b0, 1'b0, 1'b1, 1'b0});

    // 3: carry out, then chained carry-in
    run("add_wrap", 32'hFFFF_FFFF, 32'h1, ALU_ADD, 1'b0, 1'b0, 1'b0,
        '{32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
`ifdef ALU_ISSUER_CARRY_CHAIN_EN
    chain_exp = '{32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    run("chain", 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b1, 1'b1, chain_exp);
`else
    chain_exp = '{32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    run("chain", 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b1, 1'b0, chain_exp);
`endif

    // 4: response backpressure; a competing command waits for the handshake
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    sb.push_back('{32'h30, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(32'h10, 32'h20, ALU_ADD, 1'b0, 1'b0);
    wait_rsp("bp");
    snap = bus.rsp_out;
    @(posedge clk); #1;
    sb.push_back('{32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0});
    bus.cmd_a = 32'hF0F0; bus.cmd_b = 32'h0FF0; bus.cmd_op = ALU_AND;
    bus.cmd_cin = 1'b0; bus.cmd_chain = 1'b0; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_rsp_stable", {32'd0, bus.rsp_out}, {32'd0, snap});
      chk("bp_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
      if (i < 4) @(posedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk);   // handshake edge
    @(negedge clk);
    chk("bp_ready_after", {63'd0, bus.cmd_ready}, 64'd1);
    @(posedge clk); #1;
    t0 = cyc;
    bus.cmd_valid = 1'b0;
    wait_rsp("bp_next");
    @(negedge clk);

    // 5: reset during WAIT, in-flight op discarded
    issue(32'h1234, 32'h1, ALU_ADD, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("wait_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    chk("mid_rst_alu_a", {32'd0, bus.alu_a}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", {62'd0, bus.cmd_ready, busy}, 64'd2);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
